// File: rtl/dbg_serial_tx.sv
// Serial debug transmitter: frames a WIDTH-bit word MSB first plus an even-parity
// bit on SCK/SDO under an active-low FRAME_N strobe; every output is registered.
module dbg_serial_tx #(
   parameter int WIDTH = 32,
   parameter int DIV   = 4
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic [WIDTH-1:0] DATA,
   input  logic             VALID,
   output logic             READY,
   output logic             BUSY,
   output logic             FRAME_N,
   output logic             SCK,
   output logic             SDO
);
   localparam int BCW = $clog2(WIDTH + 1);

   typedef enum logic [2:0] {IDLE, SETUP, SHIFT_HI, SHIFT_LO, GAP} state_t;

   state_t         state, state_nxt;
   logic [7:0]     div_cnt, div_nxt;
   logic [BCW-1:0] bit_cnt, bit_nxt;
   logic [WIDTH:0] sreg, sreg_nxt;
   logic           div_last, accept, in_frame;

   assign div_last = (div_cnt == 8'(DIV - 1));
   assign accept   = VALID && READY;

   always_comb begin
      state_nxt = state;
      bit_nxt   = bit_cnt;
      sreg_nxt  = sreg;
      case (state)
         IDLE: if (accept) begin
            state_nxt = SETUP;
            sreg_nxt  = {DATA, ^DATA};
            bit_nxt   = '0;
         end
         SETUP: if (div_last) state_nxt = SHIFT_HI;
         // next bit goes out as SCK falls, so it is stable across the whole high phase
         SHIFT_HI: if (div_last) begin
            state_nxt = SHIFT_LO;
            sreg_nxt  = {sreg[WIDTH-1:0], 1'b0};
         end
         SHIFT_LO: if (div_last) begin
            if (bit_cnt == BCW'(WIDTH)) begin
               state_nxt = GAP;
               bit_nxt   = '0;
            end else begin
               state_nxt = SHIFT_HI;
               bit_nxt   = bit_cnt + 1'b1;
            end
         end
         GAP: if (div_last) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
      div_nxt  = (state_nxt != state || state == IDLE) ? 8'd0 : div_cnt + 8'd1;
      in_frame = (state_nxt == SETUP) || (state_nxt == SHIFT_HI) || (state_nxt == SHIFT_LO);
   end

   // outputs are decoded from the next state so they line up with the state register
   always_ff @(posedge CLK) begin
      if (RST) begin
         state   <= IDLE;
         div_cnt <= '0;
         bit_cnt <= '0;
         sreg    <= '0;
         READY   <= 1'b0;
         BUSY    <= 1'b0;
         FRAME_N <= 1'b1;
         SCK     <= 1'b0;
         SDO     <= 1'b0;
      end else begin
         state   <= state_nxt;
         div_cnt <= div_nxt;
         bit_cnt <= bit_nxt;
         sreg    <= sreg_nxt;
         READY   <= (state_nxt == IDLE);
         BUSY    <= (state_nxt != IDLE);
         FRAME_N <= !in_frame;
         SCK     <= (state_nxt == SHIFT_HI);
         SDO     <= in_frame && sreg_nxt[WIDTH];
      end
   end
endmodule
